// File: rtl/pool.sv
// Signed running-max stage. restart seeds the accumulator with the current
// element; the result appears on dn_data four cycles after the element that
// completed it (one accumulate stage plus three output stages).
module pool #(
    parameter int NUM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    input  logic                 up_valid,
    input  logic [NUM_WIDTH-1:0] up_data,
    output logic [NUM_WIDTH-1:0] dn_data
);
    logic [NUM_WIDTH-1:0] acc, s1, s2, s3;

    // accumulate the running max, then delay it through the output stages
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            s1  <= '0;
            s2  <= '0;
            s3  <= '0;
        end else begin
            if (up_valid && (restart || $signed(up_data) > $signed(acc)))
                acc <= up_data;
            s1 <= acc;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign dn_data = s3;
endmodule

// File: rtl/pool_fifo.sv
// Small synchronous result FIFO; rd_data shows the head entry combinationally.
module pool_fifo #(
    parameter int NUM_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [NUM_WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    output logic [NUM_WIDTH-1:0] rd_data,
    output logic                 empty,
    output logic                 full
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;

    // pointers carry one extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en && !full) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/pool_ctrl.sv
// Sequencer in front of pool: counts elements/windows of a configured layer,
// captures each window max into a result FIFO and throttles new windows with
// a credit count so the FIFO can never overflow.
module pool_ctrl #(
    parameter int NUM_WIDTH  = 16,
    parameter int SIZE_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIZE_WIDTH-1:0] cfg_size,
    input  logic [SIZE_WIDTH-1:0] cfg_count,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [NUM_WIDTH-1:0]  up_data,
    input  logic                  up_valid,
    output logic                  up_ready,
    output logic [NUM_WIDTH-1:0]  dn_data,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                state, state_nx;
    logic [SIZE_WIDTH-1:0] size_r, count_r, ecnt, wcnt;
    logic [CW-1:0]         outstanding;
    logic                  accept, first, last, final_elem, dn_fire;
    logic                  fifo_empty, fifo_full;
    logic [NUM_WIDTH-1:0]  pool_out;

    assign accept     = up_valid && up_ready;
    assign first      = accept && (ecnt == '0);
    assign last       = accept && (ecnt == size_r - SIZE_WIDTH'(1));
    assign final_elem = last && (wcnt == count_r - SIZE_WIDTH'(1));
    assign dn_fire    = dn_valid && dn_ready;

    // a window in progress is never stalled; only a new window needs a credit
    assign up_ready  = (state == RUN) && ((ecnt != '0) || (outstanding < CW'(FIFO_DEPTH)));
    assign cfg_ready = (state == IDLE);
    assign dn_valid  = !fifo_empty;

    // pool result is valid this many cycles after the last element is accepted
    localparam int POOL_LAT = 4;
    pool #(.NUM_WIDTH(NUM_WIDTH)) u_pool (
        .clk      (clk),
        .rst      (rst),
        .restart  (first),
        .up_valid (accept),
        .up_data  (up_data),
        .dn_data  (pool_out)
    );

    logic [POOL_LAT-1:0] dly;

    pool_fifo #(.NUM_WIDTH(NUM_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (dly[POOL_LAT-1]),
        .wr_data (pool_out),
        .rd_en   (dn_fire),
        .rd_data (dn_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and done pulse
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            IDLE:  if (cfg_valid) state_nx = RUN;
            RUN:   if (final_elem) state_nx = DRAIN;
            DRAIN: if (outstanding == '0) begin
                       done     = 1'b1;
                       state_nx = IDLE;
                   end
            default: state_nx = IDLE;
        endcase
    end

    // config latch, element/window counters, last-element delay line
    always_ff @(posedge clk) begin
        if (rst) begin
            size_r  <= SIZE_WIDTH'(1);
            count_r <= SIZE_WIDTH'(1);
            ecnt    <= '0;
            wcnt    <= '0;
            dly     <= '0;
        end else begin
            if (state == IDLE && cfg_valid) begin
                size_r  <= (cfg_size  == '0) ? SIZE_WIDTH'(1) : cfg_size;
                count_r <= (cfg_count == '0) ? SIZE_WIDTH'(1) : cfg_count;
                ecnt    <= '0;
                wcnt    <= '0;
            end else if (accept) begin
                if (last) begin
                    ecnt <= '0;
                    wcnt <= wcnt + SIZE_WIDTH'(1);
                end else begin
                    ecnt <= ecnt + SIZE_WIDTH'(1);
                end
            end
            dly <= {dly[POOL_LAT-2:0], last};
        end
    end

    // credits: a window takes one when it starts, returns it when its result leaves
    always_ff @(posedge clk) begin
        if (rst) outstanding <= '0;
        else if (first && !dn_fire) outstanding <= outstanding + 1'b1;
        else if (!first && dn_fire) outstanding <= outstanding - 1'b1;
    end

    // the credit scheme keeps the FIFO from ever filling past capacity
    always_ff @(posedge clk) begin
        if (!rst && dly[POOL_LAT-1] && fifo_full && !dn_fire) begin
            assert (1'b0) else $error("pool_ctrl: result written to a full FIFO");
        end
    end
endmodule
